pa_core_exu_mul_seq: RTL
========================

Name: pa_core_exu_mul_seq

Overview:
Multi-cycle, parametrised integer multiplier for the EXU that implements all four RV32M multiply ops (MUL, MULH, MULHSU, MULHU). It computes a full-width product by iterating a STEP_W-bit digit of operand 2 per cycle, applies per-operand sign handling, and returns the selected half. It sits beside the ALU in the execute stage, uses a start/ready/valid handshake, and supports pipeline flush via kill.

Parameters:
DATA_W, 32, operand width in bits; must be even.
STEP_W, 8, multiplier bits consumed per CALC cycle; must divide DATA_W. N = DATA_W/STEP_W.

Ports:
clk_i  input  1  core clock; all state updates on the rising edge.
rst_n_i  input  1  reset; synchronous, active-low.
start_i  input  1  request; accepted when start_i && ready_o.
op_i  input  2  operation: 00 MUL (low half), 01 MULH (s×s, high half), 10 MULHSU (s×u, high half), 11 MULHU (u×u, high half).
data1_i  input  DATA_W  operand 1 (rs1), sampled on acceptance.
data2_i  input  DATA_W  operand 2 (rs2), sampled on acceptance.
kill_i  input  1  flush; aborts any in-flight operation.
ready_o  output  1  high in IDLE and DONE.
busy_o  output  1  high in CALC.
valid_o  output  1  one-cycle result strobe.
data_o  output  DATA_W  result; holds its value until the next valid_o.

Behaviour:
- Reset (rst_n_i=0 at a clock edge): state=IDLE; valid_o=0, busy_o=0, ready_o=1 after the edge; data_o=0; internal accumulator, counter and operand registers cleared. Reset dominates kill_i and start_i.
- States: IDLE, CALC, DONE.
  - IDLE: on start_i, latch op_i, |data1_i|, |data2_i| and neg = sign1 XOR sign2, then go to CALC with the counter at 0.
  - CALC: each cycle, acc += mag1 * digit[count], shifted left by count*STEP_W. acc is 2*DATA_W bits; no overflow is possible. When count == N-1, go to DONE; otherwise count++.
  - DONE: valid_o=1 for exactly this cycle; data_o is updated at the entry edge. If start_i is asserted in DONE, accept it and go to CALC (back-to-back); otherwise go to IDLE.
- Sign rules:
  - sign1 = data1_i[MSB] for MULH and MULHSU; 0 otherwise.
  - sign2 = data2_i[MSB] for MULH only.
  - MUL uses the unsigned path; its low half is identical for signed operands.
  - Magnitudes use two's-complement negation. The most negative value maps to 2^(DATA_W-1), which fits unsigned.
  - Final product = neg ? (~acc + 1) : acc, over the full 2*DATA_W bits.
  - A zero product with neg=1 gives 0.
- Output select: MUL returns product[DATA_W-1:0]; all others return product[2*DATA_W-1:DATA_W].
- Latency: acceptance at edge k gives CALC on cycles k+1..k+N and valid_o high in cycle k+N+1. With defaults, N=4 and valid_o is high 5 cycles after acceptance.
- Throughput: one result every N+1 cycles with back-to-back starts.
- start_i during CALC: ignored. ready_o=0, no queuing, latched operands unchanged.
- kill_i in CALC or DONE: next state IDLE; valid_o suppressed (0) in the following cycle; data_o unchanged.
- kill_i and start_i together in IDLE: kill wins, request not accepted.
- kill_i in the same cycle valid_o is high: that strobe still stands. Kill only affects subsequent cycles.
- Operand inputs are don't-care except in the accepting cycle.

Test Plan:
- MUL: data1=7, data2=0xFFFFFFFD (-3), op=00. Required: valid_o exactly 5 cycles after acceptance, data_o=0xFFFFFFEB, busy_o high for 4 cycles.
- MULH and MULHU:
  - op=01, 0x80000000 × 0x80000000 -> data_o=0x40000000.
  - op=11, 0xFFFFFFFF × 0xFFFFFFFF -> data_o=0xFFFFFFFE.
- MULHSU: op=10, data1=0xFFFFFFFF (-1), data2=0xFFFFFFFF (unsigned) -> data_o=0xFFFFFFFF.
- MULH with zero: op=01, data1=0xFFFFFFFB (-5), data2=0 -> data_o=0x00000000.
- Handshake and back-to-back:
  - Pulse start_i again during CALC -> ignored; a single valid_o with the first result.
  - Assert start_i in DONE -> second valid_o exactly 5 cycles later, correct second result.
- Abort paths:
  - kill_i in the 2nd CALC cycle -> no valid_o; data_o keeps the prior value; ready_o=1 next cycle.
  - rst_n_i=0 mid-CALC -> all outputs reset, no valid_o.
  - Next start after either abort -> correct result.
- Parameter sweep: STEP_W=1, 4, 16 at DATA_W=32, random ops vs. a reference model. Latency must equal DATA_W/STEP_W+1.

Source files
------------

// File: rtl/pa_core_exu_mul_seq_if.sv
// Request/result bundle for the sequential RV32M multiplier.
// The master drives the request side; the slave (the multiplier) returns status and result.
interface pa_core_exu_mul_seq_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic              kill_i;
  logic              ready_o;
  logic              busy_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;

  modport master (
    output start_i, op_i, data1_i, data2_i, kill_i,
    input  ready_o, busy_o, valid_o, data_o
  );

  modport slave (
    input  start_i, op_i, data1_i, data2_i, kill_i,
    output ready_o, busy_o, valid_o, data_o
  );
endinterface

// File: rtl/pa_core_exu_mul_seq.sv
// Sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU): one STEP_W digit of rs2 per cycle, result DATA_W/STEP_W+1 cycles after accept.
// Accepts only when ready_o (IDLE/DONE); start during CALC is dropped, kill returns to IDLE without a strobe.
module pa_core_exu_mul_seq #(
  parameter int DATA_W = 32,
  parameter int STEP_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  pa_core_exu_mul_seq_if.slave mul_if
);
  localparam int N     = DATA_W / STEP_W;
  localparam int ACC_W = 2 * DATA_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [ACC_W-1:0]  mcand_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              sign1;
  logic              sign2;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  product_d;
  logic [DATA_W-1:0] result_d;
  logic              accept;

  always_comb begin
    sign1     = 1'b0;
    sign2     = 1'b0;
    mag1      = mul_if.data1_i;
    mag2      = mul_if.data2_i;
    acc_d     = acc_q;
    product_d = '0;
    result_d  = '0;
    accept    = 1'b0;

    sign1 = mul_if.data1_i[DATA_W-1] && (mul_if.op_i == OP_MULH || mul_if.op_i == OP_MULHSU);
    sign2 = mul_if.data2_i[DATA_W-1] && (mul_if.op_i == OP_MULH);
    // Most negative input negates to itself, which reads correctly as 2^(DATA_W-1) unsigned.
    if (sign1) mag1 = ~mul_if.data1_i + DATA_W'(1);
    if (sign2) mag2 = ~mul_if.data2_i + DATA_W'(1);

    // mcand_q already carries the count*STEP_W shift, so only the low digit of mplier_q is used.
    acc_d     = acc_q + mcand_q * {{(ACC_W-STEP_W){1'b0}}, mplier_q[STEP_W-1:0]};
    product_d = neg_q ? (~acc_d + ACC_W'(1)) : acc_d;
    result_d  = (op_q == OP_MUL) ? product_d[DATA_W-1:0] : product_d[ACC_W-1:DATA_W];

    accept = mul_if.start_i && !mul_if.kill_i && (state_q == IDLE || state_q == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q  <= CALC;
            op_q     <= mul_if.op_i;
            neg_q    <= sign1 ^ sign2;
            mcand_q  <= {{DATA_W{1'b0}}, mag1};
            mplier_q <= mag2;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (mul_if.kill_i) begin
            state_q <= IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << STEP_W;
            mplier_q <= mplier_q >> STEP_W;
            if (cnt_q == CNT_W'(N - 1)) begin
              state_q <= DONE;
              data_q  <= result_d;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_if.ready_o = (state_q != CALC);
  assign mul_if.busy_o  = (state_q == CALC);
  assign mul_if.valid_o = (state_q == DONE);
  assign mul_if.data_o  = data_q;
endmodule
